// File: rtl/ram_cfg_pkg.sv
// Shared configuration for the parametrised single-port RAM: FSM states,
// default parameter values and a width helper.
package ram_cfg_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } ram_state_e;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_DEPTH          = 64;
  localparam int DEF_READ_LATENCY   = 1;
  localparam int DEF_CLEAR_ON_RESET = 1;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Delay line carrying {valid, err, data} of reads towards the outputs.
// Data in each stage only advances with a valid read so the tail holds the last read.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [STAGES:0]       v_tap;
  logic [STAGES:0]       e_tap;
  logic [DATA_WIDTH-1:0] d_tap [STAGES+1];

  assign v_tap[0] = in_valid;
  assign e_tap[0] = in_err;
  assign d_tap[0] = in_data;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic                  valid_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (srst) begin
        valid_reg <= 1'b0;
        err_reg   <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= v_tap[gi];
        err_reg   <= e_tap[gi];
        if (v_tap[gi]) data_reg <= d_tap[gi];
      end
    end

    assign v_tap[gi+1] = valid_reg;
    assign e_tap[gi+1] = err_reg;
    assign d_tap[gi+1] = data_reg;
  end

  assign out_valid = v_tap[STAGES];
  assign out_err   = e_tap[STAGES];
  assign out_data  = d_tap[STAGES];

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM with byte enables, post-reset clear sequence,
// Ready handshake, configurable read latency and out-of-range detection.
module param_sp_ram
  import ram_cfg_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             Enable,
  input  logic                             Write_en,
  input  logic [bytes_per_word(DATA_WIDTH)-1:0] Byte_en,
  input  logic [ADDR_WIDTH-1:0]            Address,
  input  logic [DATA_WIDTH-1:0]            Data_in,
  output logic [DATA_WIDTH-1:0]            Data_out,
  output logic                             Valid_out,
  output logic                             Ready,
  output logic                             Addr_err
);

  localparam int NUM_BYTES = bytes_per_word(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("param_sp_ram: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("param_sp_ram: READ_LATENCY must be 1..3");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sp_ram: DEPTH must be >= 2");
  end

  ram_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= RST;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      RST: begin
        clr_addr_next = '0;
        state_next    = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      end
      CLEAR: begin
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == LAST_ADDR) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = RST;
    endcase
  end

  logic ready_int, accept, in_range, clearing;
  logic wr_en, rd_accept;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]  wr_be;

  assign ready_int = (state_reg == RUN) && !Reset;
  assign accept    = Enable && ready_int;
  assign in_range  = ({1'b0, Address} < DEPTH_W);
  assign clearing  = (state_reg == CLEAR) && !Reset;
  assign rd_accept = accept && !Write_en && in_range;

  // The clear sequence borrows the single write port; user writes cannot collide
  // with it because Ready is low throughout.
  assign wr_en   = clearing || (accept && Write_en && in_range);
  assign wr_addr = clearing ? clr_addr_reg : Address;
  assign wr_data = clearing ? '0 : Data_in;
  assign wr_be   = clearing ? {NUM_BYTES{1'b1}} : Byte_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q_reg;

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_accept) ram_q_reg <= mem[wr_addr];
  end

  // First read stage; zero_reg masks the unreset RAM register after reset and
  // for out-of-range reads, so the RAM output register stays reset-free.
  logic rd_valid_reg, rd_err_reg, zero_reg;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      zero_reg     <= 1'b1;
    end else begin
      rd_valid_reg <= accept && !Write_en;
      rd_err_reg   <= accept && !in_range;
      if (accept && !Write_en) zero_reg <= !in_range;
    end
  end

  assign rd_data = zero_reg ? '0 : ram_q_reg;

  ram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .STAGES    (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk      (Clock),
    .srst     (Reset),
    .in_valid (rd_valid_reg),
    .in_err   (rd_err_reg),
    .in_data  (rd_data),
    .out_valid(Valid_out),
    .out_err  (Addr_err),
    .out_data (Data_out)
  );

  assign Ready = ready_int;

endmodule

// File: tb/tb_param_sp_ram.sv
// Directed bench for param_sp_ram: clear timing, byte lanes, pipelining,
// dropped requests, out-of-range handling and reset during a read.
module tb_param_sp_ram;
  import ram_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en64, en48, en_nc;
  logic        we;
  logic [3:0]  be;
  logic [5:0]  addr;
  logic [31:0] din;

  logic [31:0] dout64, dout48, dout_nc;
  logic        vld64, vld48, vld_nc;
  logic        rdy64, rdy48, rdy_nc;
  logic        err64, err48, err_nc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  param_sp_ram #(.DATA_WIDTH(32), .DEPTH(64), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut64 (
    .Clock(clk), .Reset(rst), .Enable(en64), .Write_en(we), .Byte_en(be),
    .Address(addr), .Data_in(din), .Data_out(dout64), .Valid_out(vld64),
    .Ready(rdy64), .Addr_err(err64));

  param_sp_ram #(.DATA_WIDTH(32), .DEPTH(48), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut48 (
    .Clock(clk), .Reset(rst), .Enable(en48), .Write_en(we), .Byte_en(be),
    .Address(addr), .Data_in(din), .Data_out(dout48), .Valid_out(vld48),
    .Ready(rdy48), .Addr_err(err48));

  param_sp_ram #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_nc (
    .Clock(clk), .Reset(rst), .Enable(en_nc), .Write_en(we), .Byte_en(be),
    .Address(addr[3:0]), .Data_in(din), .Data_out(dout_nc), .Valid_out(vld_nc),
    .Ready(rdy_nc), .Addr_err(err_nc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first64, first48, first_nc, vld_seen;

    rst = 1'b1; en64 = 1'b0; en48 = 1'b0; en_nc = 1'b0;
    we = 1'b0; be = 4'h0; addr = '0; din = '0;
    repeat (3) tick();
    check("rst_dout", dout64, 32'h0);
    check("rst_valid", {31'b0, vld64}, 32'h0);
    check("rst_ready", {31'b0, rdy64}, 32'h0);
    check("rst_err", {31'b0, err64}, 32'h0);

    // Release reset; a write is attempted on dut64 while it is still clearing.
    rst = 1'b0;
    first64 = 0; first48 = 0; first_nc = 0; vld_seen = 0;
    for (int n = 1; n <= 80; n++) begin
      if (n == 10) begin
        en64 = 1'b1; we = 1'b1; addr = 6'd0; din = 32'hFFFF_FFFF; be = 4'hF;
      end else if (n == 11) begin
        en64 = 1'b0; we = 1'b0;
      end
      tick();
      if (rdy64 && first64 == 0) first64 = n;
      if (rdy48 && first48 == 0) first48 = n;
      if (rdy_nc && first_nc == 0) first_nc = n;
      if (vld64) vld_seen++;
    end
    check("ready_rise_64", first64, 65);
    check("ready_rise_48", first48, 49);
    check("ready_rise_noclear", first_nc, 1);
    check("no_valid_during_clear", vld_seen, 0);

    // Cleared top address reads zero after two cycles.
    en64 = 1'b1; we = 1'b0; addr = 6'd63; tick(); en64 = 1'b0;
    check("rd63_latency", {31'b0, vld64}, 32'h0);
    tick();
    check("rd63_valid", {31'b0, vld64}, 32'h1);
    check("rd63_data", dout64, 32'h0);

    // Write dropped while not ready.
    en64 = 1'b1; addr = 6'd0; tick(); en64 = 1'b0; tick();
    check("rd0_valid", {31'b0, vld64}, 32'h1);
    check("rd0_data", dout64, 32'h0);

    // Byte lanes, with the read issued the cycle right after the masked write.
    en64 = 1'b1; we = 1'b1; addr = 6'd5; din = 32'hDEAD_BEEF; be = 4'b1111; tick();
    din = 32'h0000_AA00; be = 4'b0010; tick();
    check("wr_no_valid", {31'b0, vld64}, 32'h0);
    we = 1'b0; tick(); en64 = 1'b0; tick();
    check("lanes_valid", {31'b0, vld64}, 32'h1);
    check("lanes_data", dout64, 32'hDEAD_AAEF);

    // Byte_en=0 write is a no-op and leaves Data_out untouched.
    en64 = 1'b1; we = 1'b1; din = 32'h1234_5678; be = 4'b0000; tick(); en64 = 1'b0; we = 1'b0; tick();
    check("be0_dout_hold", dout64, 32'hDEAD_AAEF);
    en64 = 1'b1; tick(); en64 = 1'b0; tick();
    check("be0_data", dout64, 32'hDEAD_AAEF);

    // Back-to-back reads.
    be = 4'hF; we = 1'b1; en64 = 1'b1;
    addr = 6'd1; din = 32'h11; tick();
    addr = 6'd2; din = 32'h22; tick();
    addr = 6'd3; din = 32'h33; tick();
    we = 1'b0;
    addr = 6'd1; tick();
    check("pipe_lat", {31'b0, vld64}, 32'h0);
    addr = 6'd2; tick();
    check("pipe1_valid", {31'b0, vld64}, 32'h1);
    check("pipe1_data", dout64, 32'h11);
    addr = 6'd3; tick(); en64 = 1'b0;
    check("pipe2_valid", {31'b0, vld64}, 32'h1);
    check("pipe2_data", dout64, 32'h22);
    tick();
    check("pipe3_valid", {31'b0, vld64}, 32'h1);
    check("pipe3_data", dout64, 32'h33);
    tick();
    check("pipe_idle_valid", {31'b0, vld64}, 32'h0);
    check("pipe_hold_data", dout64, 32'h33);

    // Out-of-range on the 48-deep instance.
    en48 = 1'b1; we = 1'b1; addr = 6'd50; din = 32'hCAFE_F00D; tick();
    we = 1'b0; en48 = 1'b0; tick();
    check("oor_wr_err", {31'b0, err48}, 32'h1);
    check("oor_wr_novalid", {31'b0, vld48}, 32'h0);
    en48 = 1'b1; addr = 6'd50; tick(); en48 = 1'b0;
    check("oor_rd_early_err", {31'b0, err48}, 32'h0);
    tick();
    check("oor_rd_valid", {31'b0, vld48}, 32'h1);
    check("oor_rd_err", {31'b0, err48}, 32'h1);
    check("oor_rd_data", dout48, 32'h0);
    en48 = 1'b1; addr = 6'd2; tick();
    addr = 6'd18; tick();
    check("alias2_err", {31'b0, err48}, 32'h0);
    check("alias2_data", dout48, 32'h0);
    addr = 6'd47; tick(); en48 = 1'b0;
    check("alias18_data", dout48, 32'h0);
    tick();
    check("last_valid", {31'b0, vld48}, 32'h1);
    check("last_err", {31'b0, err48}, 32'h0);

    // Latency-1, no-clear instance.
    en_nc = 1'b1; we = 1'b1; addr = 6'd15; din = 32'h1234_5678; be = 4'hF; tick();
    din = 32'h00AB_0000; be = 4'b0100; tick();
    we = 1'b0; tick(); en_nc = 1'b0;
    check("nc_valid", {31'b0, vld_nc}, 32'h1);
    check("nc_data", dout_nc, 32'h12AB_5678);
    tick();
    check("nc_idle_valid", {31'b0, vld_nc}, 32'h0);
    check("nc_hold_data", dout_nc, 32'h12AB_5678);
    check("nc_err", {31'b0, err_nc}, 32'h0);

    // Reset while a read is in flight.
    en64 = 1'b1; we = 1'b0; addr = 6'd5; tick(); en64 = 1'b0;
    rst = 1'b1; tick();
    check("midrst_valid", {31'b0, vld64}, 32'h0);
    check("midrst_dout", dout64, 32'h0);
    check("midrst_ready", {31'b0, rdy64}, 32'h0);
    tick();
    check("midrst_valid2", {31'b0, vld64}, 32'h0);
    rst = 1'b0;
    first64 = 0; vld_seen = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (rdy64 && first64 == 0) first64 = n;
      if (vld64) vld_seen++;
    end
    check("reclear_ready_rise", first64, 65);
    check("reclear_no_valid", vld_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
